// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM, redirect and decoder handshake bundle for instr_fetch
// Interrupt signals exist only when INSTR_FETCH_INTR_EN is defined.
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       fetch_count;
`ifdef INSTR_FETCH_INTR_EN
  logic              intr_req;
  logic              reti;
  logic              intr_ack;
  logic [ADDR_W-1:0] epc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  jump_en,
    input  jump_addr,
    input  halt,
    output instr_out,
    output pc_out,
    output instr_valid,
    input  instr_ready,
    output fetch_count,
    input  intr_req,
    input  reti,
    output intr_ack,
    output epc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output jump_en,
    output jump_addr,
    output halt,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    output instr_ready,
    input  fetch_count,
    output intr_req,
    output reti,
    input  intr_ack,
    input  epc
  );
`else
  modport master (
    output imem_addr,
    input  imem_data,
    input  jump_en,
    input  jump_addr,
    input  halt,
    output instr_out,
    output pc_out,
    output instr_valid,
    input  instr_ready,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output jump_en,
    output jump_addr,
    output halt,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    output instr_ready,
    input  fetch_count
  );
`endif
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, ROM addressing, IR with valid/ready output
// Optional interrupt vector redirect enabled by defining INSTR_FETCH_INTR_EN.
module instr_fetch #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] INTR_VEC = ADDR_W'('h80)
) (
  input  logic       clock,
  input  logic       reset,
  instr_fetch_if.master bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              valid;
  logic [15:0]       count;
  logic              seq_load;
  logic              load;

  // Sequential fetch happens whenever the IR is empty or is being consumed.
  assign seq_load = !bus.halt && (!valid || bus.instr_ready);

`ifdef INSTR_FETCH_INTR_EN
  logic              ie;
  logic              ack;
  logic [ADDR_W-1:0] epc;
  logic              take_reti;
  logic              take_intr;

  always_comb begin
    take_reti = bus.reti && !bus.jump_en;
    take_intr = bus.intr_req && ie && !bus.jump_en && !bus.reti && seq_load;
  end

  always_comb begin
    fetch_addr = pc;
    load       = bus.jump_en || take_reti || seq_load;
    if (bus.jump_en)
      fetch_addr = bus.jump_addr;
    else if (take_reti)
      fetch_addr = epc;
    else if (take_intr)
      fetch_addr = INTR_VEC;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ie  <= 1'b1;
      epc <= '0;
      ack <= 1'b0;
    end else begin
      ack <= take_intr;
      if (take_intr) begin
        epc <= pc;
        ie  <= 1'b0;
      end else if (take_reti) begin
        ie  <= 1'b1;
      end
    end
  end

  assign bus.intr_ack = ack;
  assign bus.epc      = epc;
`else
  always_comb begin
    fetch_addr = bus.jump_en ? bus.jump_addr : pc;
    load       = bus.jump_en || seq_load;
  end

  // The vector only matters with interrupts; keep it referenced.
  wire unused_intr_vec = ^INTR_VEC;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      ir_pc <= '0;
      valid <= 1'b0;
      count <= '0;
    end else if (load) begin
      pc    <= fetch_addr + ADDR_W'(1);
      ir    <= bus.imem_data;
      ir_pc <= fetch_addr;
      valid <= 1'b1;
      if (count != 16'hffff)
        count <= count + 16'd1;
    end else if (bus.halt && valid && bus.instr_ready) begin
      valid <= 1'b0;
    end
  end

  assign bus.imem_addr   = fetch_addr;
  assign bus.instr_out   = ir;
  assign bus.pc_out      = ir_pc;
  assign bus.instr_valid = valid;
  assign bus.fetch_count = count;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a cycle-level reference model
// Interrupt scenarios run only when INSTR_FETCH_INTR_EN is defined.
module tb_instr_fetch;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'h00), .INTR_VEC(8'h80)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage must hold after each edge.
  logic       m_ok = 1'b0;
  logic [7:0] m_pc, m_ir, m_pco, m_epc;
  logic       m_valid, m_ie, m_ack;
  int         m_cnt;

  function automatic logic in_reti();
`ifdef INSTR_FETCH_INTR_EN
    return bus.reti;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic in_intr();
`ifdef INSTR_FETCH_INTR_EN
    return bus.intr_req;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_advance();
    return !bus.halt && (!m_valid || bus.instr_ready);
  endfunction

  function automatic logic m_take_intr();
    return in_intr() && m_ie && !bus.jump_en && !in_reti() && m_advance();
  endfunction

  function automatic logic [7:0] m_addr();
    if (bus.jump_en)   return bus.jump_addr;
    if (in_reti())     return m_epc;
    if (m_take_intr()) return 8'h80;
    return m_pc;
  endfunction

  always @(posedge clock) begin
    logic [7:0] a;
    logic       intr;
    if (reset) begin
      m_pc = 8'h00; m_ir = 8'h00; m_pco = 8'h00; m_valid = 1'b0; m_cnt = 0;
      m_ie = 1'b1; m_epc = 8'h00; m_ack = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      intr = m_take_intr();
      if (bus.jump_en || in_reti() || m_advance()) begin
        a = m_addr();
        if (intr) begin
          m_epc = m_pc;
          m_ie  = 1'b0;
        end else if (in_reti() && !bus.jump_en) begin
          m_ie  = 1'b1;
        end
        m_ir    = mem[a];
        m_pco   = a;
        m_valid = 1'b1;
        m_pc    = 8'(a + 8'd1);
        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_ack   = intr;
      end else begin
        if (m_valid && bus.instr_ready) m_valid = 1'b0;
        m_ack = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (m_ok) begin
      chk("cyc_valid", 32'(bus.instr_valid), 32'(m_valid));
      chk("cyc_instr", 32'(bus.instr_out),   32'(m_ir));
      chk("cyc_pc_out", 32'(bus.pc_out),     32'(m_pco));
      chk("cyc_count", 32'(bus.fetch_count), 32'(m_cnt));
      chk("cyc_imem_addr", 32'(bus.imem_addr), 32'(m_addr()));
`ifdef INSTR_FETCH_INTR_EN
      chk("cyc_intr_ack", 32'(bus.intr_ack), 32'(m_ack));
      chk("cyc_epc", 32'(bus.epc), 32'(m_epc));
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5a;
    mem[8'h00] = 8'hcf;
    mem[8'h01] = 8'hda;
    mem[8'h02] = 8'h0b;
    mem[8'h14] = 8'h11;
    mem[8'hff] = 8'h3c;
    mem[8'h80] = 8'he1;

    reset           = 1'b1;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = 8'h00;
    bus.halt        = 1'b0;
    bus.instr_ready = 1'b1;
`ifdef INSTR_FETCH_INTR_EN
    bus.intr_req    = 1'b0;
    bus.reti        = 1'b0;
`endif
    tick(); tick();
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_count", 32'(bus.fetch_count), 32'h0);
    chk("rst_pc_out", 32'(bus.pc_out), 32'h0);
    chk("rst_instr", 32'(bus.instr_out), 32'h0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0);

    // Sequential fetch
    reset = 1'b0;
    tick(); chk("seq0_instr", 32'(bus.instr_out), 32'hcf); chk("seq0_pc", 32'(bus.pc_out), 32'h00);
    tick(); chk("seq1_instr", 32'(bus.instr_out), 32'hda); chk("seq1_pc", 32'(bus.pc_out), 32'h01);

    // Back-pressure
    bus.instr_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_instr", 32'(bus.instr_out), 32'hda);
      chk("bp_pc", 32'(bus.pc_out), 32'h01);
      chk("bp_imem_addr", 32'(bus.imem_addr), 32'h02);
    end
    bus.instr_ready = 1'b1;
    tick(); chk("seq2_instr", 32'(bus.instr_out), 32'h0b); chk("seq2_pc", 32'(bus.pc_out), 32'h02);
    chk("seq_count", 32'(bus.fetch_count), 32'd3);

    // Jump during stall
    tick(); tick(); chk("pre_jump_pc", 32'(bus.pc_out), 32'h04);
    bus.instr_ready = 1'b0;
    tick(); chk("stall_pc", 32'(bus.pc_out), 32'h04);
    bus.jump_en = 1'b1; bus.jump_addr = 8'h14;
    tick(); chk("jmp_instr", 32'(bus.instr_out), 32'h11); chk("jmp_pc", 32'(bus.pc_out), 32'h14);
    bus.jump_en = 1'b0;
    #1; chk("jmp_imem_addr", 32'(bus.imem_addr), 32'h15); chk("jmp_count", 32'(bus.fetch_count), 32'd6);

    // PC wrap
    bus.instr_ready = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 8'hff;
    tick(); chk("wrap_pc_ff", 32'(bus.pc_out), 32'hff); chk("wrap_instr_ff", 32'(bus.instr_out), 32'h3c);
    bus.jump_en = 1'b0;
    tick(); chk("wrap_pc_00", 32'(bus.pc_out), 32'h00); chk("wrap_instr_00", 32'(bus.instr_out), 32'hcf);
    chk("wrap_imem_addr", 32'(bus.imem_addr), 32'h01);

    // Halt with ready
    bus.halt = 1'b1;
    tick(); chk("halt_valid", 32'(bus.instr_valid), 32'h0); chk("halt_count", 32'(bus.fetch_count), 32'd8);
    tick(); chk("halt_valid2", 32'(bus.instr_valid), 32'h0); chk("halt_count2", 32'(bus.fetch_count), 32'd8);

    // Jump and halt together, then halt takes over
    bus.jump_en = 1'b1; bus.jump_addr = 8'h14;
    tick(); chk("jh_valid", 32'(bus.instr_valid), 32'h1); chk("jh_pc", 32'(bus.pc_out), 32'h14);
    bus.jump_en = 1'b0;
    tick(); chk("jh_valid2", 32'(bus.instr_valid), 32'h0); chk("jh_count", 32'(bus.fetch_count), 32'd9);

    // Reset in the middle of a stall with a jump pending
    bus.halt = 1'b0; bus.instr_ready = 1'b0;
    tick(); chk("pre_rst_pc", 32'(bus.pc_out), 32'h15);
    tick();
    reset = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 8'h33;
    tick(); chk("mrst_valid", 32'(bus.instr_valid), 32'h0); chk("mrst_count", 32'(bus.fetch_count), 32'h0);
    reset = 1'b0; bus.jump_en = 1'b0;
    #1; chk("mrst_imem_addr", 32'(bus.imem_addr), 32'h00);
    bus.instr_ready = 1'b1;

`ifdef INSTR_FETCH_INTR_EN
    repeat (5) tick();
    chk("intr_pre_pc", 32'(bus.pc_out), 32'h04);
    bus.intr_req = 1'b1;
    tick(); chk("intr_ack", 32'(bus.intr_ack), 32'h1); chk("intr_pc", 32'(bus.pc_out), 32'h80);
    chk("intr_instr", 32'(bus.instr_out), 32'he1); chk("intr_epc", 32'(bus.epc), 32'h05);
    tick(); chk("intr2_ack", 32'(bus.intr_ack), 32'h0); chk("intr2_pc", 32'(bus.pc_out), 32'h81);
    bus.intr_req = 1'b0; bus.reti = 1'b1;
    tick(); chk("reti_pc", 32'(bus.pc_out), 32'h05);
    bus.reti = 1'b0;
    tick(); chk("reti_next_pc", 32'(bus.pc_out), 32'h06);
    bus.intr_req = 1'b1;
    tick(); chk("intr3_pc", 32'(bus.pc_out), 32'h80); chk("intr3_ack", 32'(bus.intr_ack), 32'h1);
    chk("intr3_epc", 32'(bus.epc), 32'h07);
    bus.intr_req = 1'b0;
`endif

    // Saturation of the load counter
    repeat (65540) tick();
    chk("sat_count", 32'(bus.fetch_count), 32'hffff);
    tick(); chk("sat_count_hold", 32'(bus.fetch_count), 32'hffff);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
